// File: rtl/fft_stream_ctrl.sv
// ADC-to-FFT sink framing with single/continuous capture, plus FFT-source
// per-bin power with bin tagging and per-frame peak detection.
//
// state  | meaning
// S_IDLE | not capturing; adc_valid ignored, waiting for start
// S_RUN  | framing samples into the FFT sink
// S_GAP  | inter-frame idle in continuous mode; samples discarded
module fft_stream_ctrl #(
  parameter int ADC_W   = 10,
  parameter int DATA_W  = 12,
  parameter int OUT_W   = 12,
  parameter int FFT_LEN = 1024,
  parameter int OFFSET  = 512,
  parameter int GAP     = 0,
  localparam int IDX_W  = $clog2(FFT_LEN),
  localparam int PWR_W  = 2 * OUT_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [OUT_W-1:0]  source_real,
  input  logic [OUT_W-1:0]  source_imag,
  output logic              source_ready,
  output logic [PWR_W-1:0]  pwr,
  output logic              pwr_valid,
  output logic              pwr_sop,
  output logic              pwr_eop,
  output logic [IDX_W-1:0]  pwr_bin,
  output logic [IDX_W-1:0]  peak_bin,
  output logic [PWR_W-1:0]  peak_pwr,
  output logic              peak_valid,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FFT_LEN - 1);
  localparam int                GAP_LD   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [DATA_W-1:0] OFS      = DATA_W'(OFFSET);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              mode_q;
  logic              stop_pend;
  logic [15:0]       gap_cnt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] conv;
  logic              xfer, last_xfer, end_frame, leave_run, load, drop;

  assign conv      = {{(DATA_W-ADC_W){1'b0}}, adc_data} - OFS;
  assign xfer      = hold_full && sink_ready;
  assign last_xfer = xfer && (idx == IDX_LAST);
  assign end_frame = !mode_q || stop_pend || stop;
  // A sample arriving on the closing transfer belongs to no frame when RUN is left.
  assign leave_run = last_xfer && (end_frame || (GAP != 0));
  assign load      = adc_valid && (state == S_RUN) && (!hold_full || xfer) && !leave_run;
  assign drop      = adc_valid && (state == S_RUN) && hold_full && !xfer;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      mode_q    <= 1'b0;
      stop_pend <= 1'b0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            idx       <= '0;
            mode_q    <= mode;
            stop_pend <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (xfer) begin
            if (last_xfer) begin
              frame_cnt <= frame_cnt + 16'd1;
              idx       <= '0;
              if (end_frame) begin
                state <= S_IDLE;
              end else if (GAP != 0) begin
                state   <= S_GAP;
                gap_cnt <= 16'(GAP_LD);
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_GAP: begin
          if (stop) stop_pend <= 1'b1;
          if (gap_cnt == 16'd0) state <= (stop_pend || stop) ? S_IDLE : S_RUN;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (load) begin
        hold_full <= 1'b1;
        hold_data <= conv;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end
      if (drop) err_ovf <= 1'b1;
    end
  end

  assign sink_valid   = hold_full;
  assign sink_real    = hold_data;
  assign sink_imag    = '0;
  assign sink_sop     = hold_full && (idx == '0);
  assign sink_eop     = hold_full && (idx == IDX_LAST);
  assign source_ready = 1'b1;
  assign busy         = (state != S_IDLE);

  logic signed [PWR_W-1:0] re_x, im_x, re_prod, im_prod;
  logic [PWR_W-1:0]        re_sq, im_sq;
  logic                    s1_valid, s1_sop, s1_eop;
  logic [IDX_W-1:0]        s1_bin, bin_cnt;

  assign re_x    = {{OUT_W{source_real[OUT_W-1]}}, source_real};
  assign im_x    = {{OUT_W{source_imag[OUT_W-1]}}, source_imag};
  assign re_prod = re_x * re_x;
  assign im_prod = im_x * im_x;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      re_sq     <= '0;
      im_sq     <= '0;
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_bin    <= '0;
      bin_cnt   <= '0;
      pwr       <= '0;
      pwr_valid <= 1'b0;
      pwr_sop   <= 1'b0;
      pwr_eop   <= 1'b0;
      pwr_bin   <= '0;
    end else begin
      s1_valid <= source_valid;
      s1_sop   <= source_valid && source_sop;
      s1_eop   <= source_valid && source_eop;
      if (source_valid) begin
        re_sq   <= re_prod;
        im_sq   <= im_prod;
        s1_bin  <= source_sop ? '0 : bin_cnt;
        bin_cnt <= source_sop ? IDX_W'(1) : bin_cnt + IDX_W'(1);
      end
      pwr_valid <= s1_valid;
      pwr_sop   <= s1_sop;
      pwr_eop   <= s1_eop;
      if (s1_valid) begin
        pwr     <= re_sq + im_sq;
        pwr_bin <= s1_bin;
      end
    end
  end

  logic [PWR_W-1:0] run_pwr, cand_pwr;
  logic [IDX_W-1:0] run_bin, cand_bin;
  logic             take;

  // Strict compare keeps the lowest bin on ties.
  assign take     = pwr_sop || (pwr > run_pwr);
  assign cand_pwr = take ? pwr : run_pwr;
  assign cand_bin = take ? pwr_bin : run_bin;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_pwr    <= '0;
      run_bin    <= '0;
      peak_pwr   <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      if (pwr_valid) begin
        run_pwr <= cand_pwr;
        run_bin <= cand_bin;
      end
      peak_valid <= pwr_valid && pwr_eop;
      if (pwr_valid && pwr_eop) begin
        peak_pwr <= cand_pwr;
        peak_bin <= cand_bin;
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Randomized and directed bench for fft_stream_ctrl with a queue/array based
// reference model of sink framing and source power/peak reporting.
module tb_fft_stream_ctrl;
  localparam int ADC_W = 10, DATA_W = 12, OUT_W = 12, LEN = 16, OFFSET = 512, GAP = 4;
  localparam int IDX_W = 4, PWR_W = 24;

  logic sys_clk = 1'b0, sys_rst_n = 1'b1;
  logic [ADC_W-1:0] adc_data = '0;
  logic adc_valid = 0, start = 0, stop = 0, mode = 0, sink_ready = 0;
  logic sink_valid, sink_sop, sink_eop;
  logic [DATA_W-1:0] sink_real, sink_imag;
  logic source_valid = 0, source_sop = 0, source_eop = 0;
  logic [OUT_W-1:0] source_real = '0, source_imag = '0;
  logic source_ready;
  logic [PWR_W-1:0] pwr, peak_pwr;
  logic pwr_valid, pwr_sop, pwr_eop, peak_valid, busy, err_ovf;
  logic [IDX_W-1:0] pwr_bin, peak_bin;
  logic [15:0] frame_cnt;

  fft_stream_ctrl #(.ADC_W(ADC_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .FFT_LEN(LEN),
                    .OFFSET(OFFSET), .GAP(GAP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .start(start), .stop(stop), .mode(mode), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .source_ready(source_ready),
    .pwr(pwr), .pwr_valid(pwr_valid), .pwr_sop(pwr_sop), .pwr_eop(pwr_eop),
    .pwr_bin(pwr_bin), .peak_bin(peak_bin), .peak_pwr(peak_pwr), .peak_valid(peak_valid),
    .busy(busy), .frame_cnt(frame_cnt), .err_ovf(err_ovf));

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sink reference: capture activity, gap cycles left, 1-deep sample queue
  bit m_capturing, m_cont, m_stop, m_err;
  int m_gap_left, m_idx, m_frames;
  logic [DATA_W-1:0] m_q[$];

  typedef struct { bit v, sop, eop; logic [PWR_W-1:0] p; int bin;
                   bit pk; int pkb; logic [PWR_W-1:0] pkp; } ent_t;
  typedef struct { bit v, sop, eop; logic [OUT_W-1:0] re, im; } beat_t;
  beat_t src_q[$];
  ent_t h1, h2;
  int fl[$];
  int m_bin, exp_pkb;
  logic [PWR_W-1:0] exp_pkp;
  bit src_auto = 0;
  logic [OUT_W-1:0] fr_re[LEN], fr_im[LEN];

  int cyc = 0, xfer_seen, sop_seen, eop_seen, sop_cyc, eop1_cyc, se_cyc, pe_cyc, pk_cyc;
  logic [DATA_W-1:0] first_real, last_real;
  bit first_sop, stopped;
  logic [PWR_W-1:0] obs_pwr[LEN];

  task automatic clear_stats();
    xfer_seen = 0; sop_seen = 0; eop_seen = 0; sop_cyc = 0; eop1_cyc = 0;
    first_real = '0; last_real = '0; first_sop = 0;
  endtask

  task automatic push_frame(input bit gaps);
    beat_t b;
    for (int i = 0; i < LEN; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        b = '{default: 0};
        src_q.push_back(b);
      end
      b.v = 1; b.sop = (i == 0); b.eop = (i == LEN - 1); b.re = fr_re[i]; b.im = fr_im[i];
      src_q.push_back(b);
    end
  endtask

  task automatic src_drive();
    beat_t b;
    if (src_q.size() == 0 && src_auto) begin
      for (int i = 0; i < LEN; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          fr_re[i] = OUT_W'($urandom); fr_im[i] = OUT_W'($urandom);
        end else begin
          fr_re[i] = OUT_W'($urandom_range(0, 6)) - OUT_W'(3);
          fr_im[i] = OUT_W'($urandom_range(0, 1)) * OUT_W'(4);
        end
      end
      push_frame(1);
    end
    if (src_q.size() != 0) b = src_q.pop_front();
    else b = '{default: 0};
    source_valid = b.v; source_sop = b.sop; source_eop = b.eop;
    source_real = b.re; source_imag = b.im;
    if (b.v && b.eop) se_cyc = cyc;
  endtask

  task automatic src_model(output ent_t e);
    int re, im, p, best;
    e = '{default: 0};
    if (source_valid) begin
      re = int'($signed(source_real));
      im = int'($signed(source_imag));
      p = re * re + im * im;
      e.v = 1; e.sop = source_sop; e.eop = source_eop; e.p = PWR_W'(p);
      e.bin = source_sop ? 0 : m_bin;
      m_bin = (e.bin + 1) % LEN;
      if (source_sop) fl.delete();
      fl.push_back(p);
      if (source_eop) begin
        best = 0;
        for (int i = 1; i < fl.size(); i++) if (fl[i] > fl[best]) best = i;
        e.pk = 1; e.pkb = best; e.pkp = PWR_W'(fl[best]);
      end
    end
  endtask

  task automatic sink_step();
    bit xf, done;
    xf = (m_q.size() != 0) && sink_ready;
    done = 0;
    if (!m_capturing) begin
      if (start) begin
        m_capturing = 1; m_gap_left = 0; m_idx = 0; m_cont = mode; m_stop = 0;
      end
    end else if (m_gap_left > 0) begin
      if (stop) m_stop = 1;
      m_gap_left--;
      if (m_gap_left == 0 && m_stop) m_capturing = 0;
    end else begin
      if (stop) m_stop = 1;
      if (xf) begin
        void'(m_q.pop_front());
        m_idx++;
        if (m_idx == LEN) begin
          m_idx = 0;
          m_frames = (m_frames + 1) % 65536;
          if (!m_cont || m_stop) begin m_capturing = 0; done = 1; end
          else if (GAP > 0) begin m_gap_left = GAP; done = 1; end
        end
      end
      if (adc_valid && !done) begin
        if (m_q.size() == 0) m_q.push_back(DATA_W'(int'(adc_data) - OFFSET));
        else m_err = 1;
      end
    end
  endtask

  task automatic check_all();
    bit qv;
    qv = (m_q.size() != 0);
    chk("sink_valid", sink_valid, qv);
    if (qv) chk("sink_real", sink_real, m_q[0]);
    chk("sink_sop", sink_sop, qv && m_idx == 0);
    chk("sink_eop", sink_eop, qv && m_idx == LEN - 1);
    chk("sink_imag", sink_imag, 0);
    chk("source_ready", source_ready, 1);
    chk("busy", busy, m_capturing);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("err_ovf", err_ovf, m_err);
    chk("pwr_valid", pwr_valid, h1.v);
    chk("pwr_sop", pwr_sop, h1.sop);
    chk("pwr_eop", pwr_eop, h1.eop);
    if (h1.v) begin
      chk("pwr", pwr, h1.p);
      chk("pwr_bin", pwr_bin, h1.bin);
    end
    chk("peak_valid", peak_valid, h2.pk);
    if (h2.pk) begin exp_pkb = h2.pkb; exp_pkp = h2.pkp; end
    chk("peak_bin", peak_bin, exp_pkb);
    chk("peak_pwr", peak_pwr, exp_pkp);
  endtask

  task automatic cycle();
    ent_t cur;
    src_drive();
    src_model(cur);
    if (sink_valid && sink_ready) begin
      if (xfer_seen == 0) begin first_real = sink_real; first_sop = sink_sop; end
      if (sink_sop) begin sop_seen++; sop_cyc = cyc; end
      if (sink_eop) begin
        eop_seen++; last_real = sink_real;
        if (eop_seen == 1) eop1_cyc = cyc;
      end
      xfer_seen++;
    end
    @(posedge sys_clk);
    sink_step();
    @(negedge sys_clk);
    check_all();
    // outputs seen after this edge are present during the next cycle
    if (pwr_valid) obs_pwr[pwr_bin] = pwr;
    if (pwr_eop) pe_cyc = cyc + 1;
    if (peak_valid) pk_cyc = cyc + 1;
    h2 = h1; h1 = cur;
    cyc++;
  endtask

  task automatic do_reset();
    sys_rst_n = 0; adc_valid = 0; start = 0; stop = 0;
    src_q.delete();
    source_valid = 0; source_sop = 0; source_eop = 0;
    #1;
    chk("rst_sink", {sink_valid, sink_sop, sink_eop, sink_real, sink_imag}, 0);
    chk("rst_pwr", {pwr_valid, pwr_sop, pwr_eop, pwr}, 0);
    chk("rst_peak", {peak_valid, peak_bin, peak_pwr}, 0);
    chk("rst_misc", {busy, err_ovf, frame_cnt, pwr_bin}, 0);
    chk("rst_source_ready", source_ready, 1);
    m_capturing = 0; m_cont = 0; m_stop = 0; m_err = 0;
    m_gap_left = 0; m_idx = 0; m_frames = 0; m_q.delete();
    h1 = '{default: 0}; h2 = '{default: 0};
    fl.delete(); m_bin = 0; exp_pkb = 0; exp_pkp = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  initial begin
    #3;
    do_reset();

    // single frame, ramp input, no backpressure
    clear_stats();
    mode = 0; sink_ready = 1; start = 1; cycle(); start = 0;
    for (int k = 0; k < 24; k++) begin
      adc_valid = 1; adc_data = ADC_W'(k); cycle();
    end
    chk("t1_xfers", xfer_seen, 16);
    chk("t1_first", first_real, 12'hE00);
    chk("t1_first_sop", first_sop, 1);
    chk("t1_last", last_real, 12'hE0F);
    chk("t1_sop_eop", {sop_seen[7:0], eop_seen[7:0]}, 16'h0101);
    chk("t1_frames", frame_cnt, 1);
    chk("t1_busy", busy, 0);

    // backpressure for 3 cycles while samples keep arriving
    do_reset(); clear_stats();
    mode = 0; sink_ready = 1; start = 1; cycle(); start = 0;
    for (int k = 0; k < 30; k++) begin
      adc_valid = 1; adc_data = ADC_W'(k);
      sink_ready = !(k >= 6 && k <= 8);
      cycle();
    end
    chk("t2_xfers", xfer_seen, 16);
    chk("t2_sop_eop", {sop_seen[7:0], eop_seen[7:0]}, 16'h0101);
    chk("t2_err", err_ovf, 1);
    chk("t2_frames", frame_cnt, 1);

    // continuous with gaps, stop during frame 2
    do_reset(); clear_stats(); stopped = 0;
    mode = 1; sink_ready = 1; start = 1; cycle(); start = 0;
    for (int k = 0; k < 80; k++) begin
      adc_valid = 1; adc_data = ADC_W'($urandom);
      if (!stopped && xfer_seen == LEN + 5) begin stop = 1; stopped = 1; end
      else stop = 0;
      cycle();
    end
    stop = 0;
    chk("t3_frames", frame_cnt, 2);
    chk("t3_xfers", xfer_seen, 32);
    chk("t3_err", err_ovf, 0);
    chk("t3_busy", busy, 0);
    chk("t3_gap", sop_cyc - eop1_cyc, GAP + 2);

    // directed source frames
    adc_valid = 0;
    for (int i = 0; i < LEN; i++) begin fr_re[i] = '0; fr_im[i] = '0; obs_pwr[i] = '0; end
    fr_re[5] = 12'd3;   fr_im[5] = 12'hFFC;
    fr_re[9] = 12'h800; fr_im[9] = 12'h800;
    push_frame(0);
    for (int k = 0; k < 24; k++) cycle();
    chk("t4_bin5", obs_pwr[5], 25);
    chk("t4_bin9", obs_pwr[9], 8388608);
    chk("t4_peak_bin", peak_bin, 9);
    chk("t4_peak_pwr", peak_pwr, 8388608);
    chk("t4_pwr_lat", pe_cyc - se_cyc, 2);
    chk("t4_peak_lat", pk_cyc - se_cyc, 3);

    for (int i = 0; i < LEN; i++) begin fr_re[i] = '0; fr_im[i] = '0; end
    fr_re[2] = 12'd6;   fr_im[2] = 12'd8;
    fr_re[7] = 12'hFF6; fr_im[7] = 12'd0;
    push_frame(1);
    for (int k = 0; k < 30; k++) cycle();
    chk("t5_peak_bin", peak_bin, 2);
    chk("t5_peak_pwr", peak_pwr, 100);

    // randomized traffic on both paths
    src_auto = 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 300; k++) begin
        if (r == 3 && k == 150) do_reset();
        start = ($urandom_range(0, 19) == 0);
        stop = ($urandom_range(0, 49) == 0);
        mode = 1'($urandom_range(0, 1));
        adc_valid = ($urandom_range(0, 9) < 7);
        adc_data = ADC_W'($urandom);
        sink_ready = ($urandom_range(0, 9) < 8);
        cycle();
      end
    end
    start = 0; stop = 0;

    // reset in the middle of a frame, then a fresh frame
    do_reset(); clear_stats();
    mode = 0; sink_ready = 1; start = 1; cycle(); start = 0;
    for (int k = 0; k < 40 && xfer_seen < 8; k++) begin
      adc_valid = 1; adc_data = ADC_W'($urandom); cycle();
    end
    chk("t7_pre_xfers", xfer_seen, 8);
    do_reset(); clear_stats();
    mode = 0; start = 1; cycle(); start = 0;
    for (int k = 0; k < 24; k++) begin
      adc_valid = 1; adc_data = ADC_W'($urandom); cycle();
    end
    chk("t7_first_sop", first_sop, 1);
    chk("t7_xfers", xfer_seen, 16);
    chk("t7_frames", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
